uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares one serial transmitter (8N2 transmit engine with `TxD_start`/`TxD_data`/`TxD_busy`) among `NREQ` byte-stream requesters.
- Arbitration is round-robin at message granularity. A requester keeps the grant until it sends a byte marked `last`, or until its lock times out, so multi-byte messages are never interleaved.
- Sits between the debug/report sources and the transmitter; it drives the transmitter's start/data pins and watches its busy pin.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LOCK_TIMEOUT`, 1023: idle cycles a locked requester may hold the grant without presenting a byte.
- `BUSY_WAIT`, 15: cycles allowed for `tx_busy` to rise after `tx_start`.

- `clk` in 1: system clock.
- `rst_n` in 1: reset. **Asynchronous, active-low.**
- `req_valid` in NREQ: requester i has a byte pending.
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i]. Must be stable while `req_valid[i]` is high.
- `req_last` in NREQ: byte is the last of its message.
- `req_ack` out NREQ: one-cycle pulse when requester i's byte is taken. The requester drops or advances `req_valid`/`req_data` on the next cycle.
- `grant` out NREQ: one-hot owner; all-zero when no owner.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out 8: byte to the transmitter. Held from `tx_start` until the next byte.
- `tx_busy` in 1: transmitter busy.
- `err_busy` out 1: one-cycle pulse when the `BUSY_WAIT` guard expires.

## Operation
- **State after reset:** state IDLE, rr pointer 0, lock 0, all counters 0. Outputs `req_ack`, `grant`, `tx_start`, `tx_data` and `err_busy` are all 0.
- **IDLE**
  - If `tx_busy`=0 and any `req_valid`: choose the first valid index at or after the pointer, wrapping modulo NREQ.
  - At the next edge: `grant` = that one-hot, `tx_data` = its `req_data`, `tx_start`=1, `req_ack[w]`=1, lock = ~`req_last[w]`. Go to WAIT_HI.
  - If `tx_busy`=1, stay in IDLE and issue nothing.
- **WAIT_HI**
  - `tx_start` and `req_ack` return to 0.
  - When `tx_busy`=1, go to WAIT_LO.
  - If `BUSY_WAIT` cycles pass without `tx_busy`: pulse `err_busy`, clear the lock, advance the pointer to w+1, clear `grant`, go to IDLE.
- **WAIT_LO**
  - When `tx_busy`=0:
    - If lock=1, go to LOCKED and clear the timeout counter.
    - Otherwise: pointer = (w+1) mod NREQ, `grant`=0, go to IDLE.
- **LOCKED**
  - `grant` stays asserted.
  - If `req_valid[w]`=1: issue the byte exactly as in IDLE (same register updates, lock = ~`req_last[w]`), go to WAIT_HI.
  - Valid bits of other requesters are ignored.
  - Otherwise increment the timeout counter. At `LOCK_TIMEOUT`: lock=0, pointer=w+1, `grant`=0, go to IDLE.
- **Pointer update:** only at message end (`last` byte completed, timeout, or `err_busy`). It never changes mid-message.
- **Requester dropping out:** a requester deasserting `req_valid` in IDLE is simply not selected. Unacked bytes are never lost and never duplicated.
- **Mid-operation reset:** asserting `rst_n`=0 clears everything immediately, including `tx_start`. A byte already inside the transmitter completes on its own; after reset the block waits for `tx_busy`=0 before issuing.

## Timing
- **Request-to-start latency:** 1 cycle. `req_valid` is sampled at edge k; `tx_start`/`req_ack` are high during cycle k+1.
- **Transmitter handshake:** the transmitter raises `tx_busy` one cycle after sampling `tx_start`, so WAIT_HI normally lasts 1–2 cycles.
- **Back-to-back bytes of a locked message:**
  - Next `tx_start` 2 cycles after `tx_busy` falls: edge into LOCKED, then the issue edge.
  - No extra gap is required; the transmitter accepts a start in its idle state.
- **Outputs:** all outputs are registered. No combinational path from any input to any output.

## Structure
- **Package `uart_arb_pkg`:**
  - state enum (IDLE, WAIT_HI, WAIT_LO, LOCKED);
  - `clog2`-based width constants for the pointer and the timeout/busy-wait counters.
- **Sub-module `rr_pick`** (combinational): rotate-priority select of the first set bit at or after `ptr` among NREQ bits. Outputs a one-hot result and a found flag.
- **Top level:** FSM, lock bit, counters and output registers in `uart_tx_arbiter`.

## Test plan
- **Reset:** hold `rst_n`=0, toggle inputs → all outputs 0. Release; no `tx_start` while `req_valid`=0.
- **Single byte:** requester 2, data 0x41, last=1 → `tx_start` and `req_ack[2]` one cycle later with `tx_data`=0x41. `grant` returns to 0 after `tx_busy` falls; pointer becomes 3.
- **Round-robin:** all four requesters continuously valid with last=1, bytes 0x10/0x20/0x30/0x40 → transmitted order 0x10, 0x20, 0x30, 0x40, 0x10; each `req_ack` pulses exactly once per byte.
- **Message lock:** requester 1 sends 0xA0, 0xA1 (last=0) and 0xA2 (last=1) while requester 0 stays valid → all three of requester 1 go first, then requester 0's byte.
- **Lock timeout:** with `LOCK_TIMEOUT`=8, requester 3 sends a byte with last=0 then drops valid; requester 0 is valid → 8 cycles after `tx_busy` falls, the grant is released and requester 0 is served next.
- **Busy fault:** bench holds `tx_busy`=0 after `tx_start` → `err_busy` pulses `BUSY_WAIT`=15 cycles later, the FSM returns to IDLE and the next requester is served.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
// The width helper sizes pointers and counters from their largest value.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_LOCKED  = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_NREQ         = 32'd4;
  localparam int unsigned DEF_LOCK_TIMEOUT = 32'd1023;
  localparam int unsigned DEF_BUSY_WAIT    = 32'd15;

  // Bits needed to hold any value in 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
// Purely combinational; found_o is low when no request is set.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = 32'd4,
  parameter int unsigned PW = cnt_width(N - 32'd1)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  int unsigned   pos_s;
  logic [PW-1:0] pos_w_s;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    pos_s    = 32'd0;
    pos_w_s  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos_s   = (32'(ptr_i) + k) % N;
      pos_w_s = PW'(pos_s);
      if (!found_o && req_i[pos_w_s]) begin
        found_o           = 1'b1;
        onehot_o[pos_w_s] = 1'b1;
        idx_o             = pos_w_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter among
// NREQ byte-stream requesters; a requester keeps the grant until its last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ         = DEF_NREQ,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned BUSY_WAIT    = DEF_BUSY_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              err_busy
);

  localparam int unsigned PW = cnt_width(NREQ - 32'd1);
  localparam int unsigned TW = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned BW = cnt_width(BUSY_WAIT);

  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 32'd1);
  localparam logic [TW-1:0] TMO_END  = TW'(LOCK_TIMEOUT - 32'd1);
  localparam logic [BW-1:0] BSY_END  = BW'(BUSY_WAIT - 32'd1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_oh_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_found_s;
  logic [NREQ-1:0] owner_oh_s;
  logic [NREQ-1:0] issue_oh_s;
  logic [PW-1:0]   issue_idx_s;
  logic [7:0]      issue_byte_s;
  logic            issue_last_s;
  logic [PW-1:0]   next_ptr_s;
  logic            issue_s;
  logic            busy_err_s;
  logic            msg_end_s;
  logic            lock_tmo_s;
  logic            enter_lock_s;
  logic            release_s;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh_s),
    .idx_o    (pick_idx_s),
    .found_o  (pick_found_s)
  );

  // In LOCKED only the owner may issue; otherwise the picker chooses.
  always_comb begin
    owner_oh_s          = '0;
    owner_oh_s[owner_q] = 1'b1;
    if (state_q == ST_LOCKED) begin
      issue_oh_s  = owner_oh_s;
      issue_idx_s = owner_q;
    end else begin
      issue_oh_s  = pick_oh_s;
      issue_idx_s = pick_idx_s;
    end
    issue_byte_s = req_data[{issue_idx_s, 3'b000} +: 8];
    issue_last_s = req_last[issue_idx_s];
    if (owner_q == LAST_IDX) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_q + PW'(1);
    end
  end

  always_comb begin
    issue_s      = ((state_q == ST_IDLE) && !tx_busy && pick_found_s) ||
                   ((state_q == ST_LOCKED) && req_valid[owner_q]);
    busy_err_s   = (state_q == ST_WAIT_HI) && !tx_busy && (bcnt_q == BSY_END);
    msg_end_s    = (state_q == ST_WAIT_LO) && !tx_busy && !lock_q;
    enter_lock_s = (state_q == ST_WAIT_LO) && !tx_busy && lock_q;
    lock_tmo_s   = (state_q == ST_LOCKED) && !req_valid[owner_q] && (tcnt_q == TMO_END);
    release_s    = busy_err_s || msg_end_s || lock_tmo_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_WAIT_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (busy_err_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (enter_lock_s) begin
          state_d = ST_LOCKED;
        end else if (msg_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_LOCKED: begin
        if (issue_s) begin
          state_d = ST_WAIT_HI;
        end else if (lock_tmo_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer moves only at message end, so a locked message is never split.
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    if (issue_s) begin
      grant_d = issue_oh_s;
      ack_d   = issue_oh_s;
      data_d  = issue_byte_s;
      start_d = 1'b1;
      lock_d  = ~issue_last_s;
      owner_d = issue_idx_s;
      bcnt_d  = '0;
    end else if (release_s) begin
      grant_d = '0;
      lock_d  = 1'b0;
      ptr_d   = next_ptr_s;
      err_d   = busy_err_s;
    end else if (enter_lock_s) begin
      tcnt_d = '0;
    end else if ((state_q == ST_WAIT_HI) && !tx_busy) begin
      bcnt_d = bcnt_q + BW'(1);
    end else if (state_q == ST_LOCKED) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ack  = ack_q;
  assign grant    = grant_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign err_busy = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a
// transmitter model answers tx_start, expected bytes are compared in order.
module tb_uart_tx_arbiter;
  localparam int NREQ   = 4;
  localparam int LOCK_T = 8;
  localparam int BUSY_W = 15;
  localparam int TX_LEN = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_last = 4'h0;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        err_busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  bit drv_en = 1'b0;
  bit xmit_en = 1'b0;
  bit fault = 1'b0;

  logic [8:0] rq [NREQ][$];
  int         exp_idx[$];
  logic [7:0] exp_dat[$];
  logic [7:0] obs_dat[$];
  logic [3:0] obs_ack[$];
  logic [3:0] obs_gnt[$];
  int         obs_cyc[$];
  int         err_cyc[$];
  int         stray = 0;
  int         fall_cyc = 0;
  int         fall_cnt = 0;
  logic       prev_busy = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LOCK_T), .BUSY_WAIT(BUSY_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .err_busy(err_busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Requesters: present queue head, advance after an ack.
  initial forever begin
    @(negedge clk);
    if (drv_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy rises one cycle after sampling tx_start.
  initial forever begin
    @(negedge clk);
    if (xmit_en && !fault && tx_start) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (TX_LEN) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      obs_dat.push_back(tx_data); obs_ack.push_back(req_ack);
      obs_gnt.push_back(grant);   obs_cyc.push_back(cyc);
    end else if (req_ack != 4'h0) begin
      stray++;
    end
    if (err_busy) err_cyc.push_back(cyc);
    if (prev_busy && !tx_busy) begin fall_cyc = cyc; fall_cnt++; end
    prev_busy = tx_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
  endtask

  task automatic expect_byte(input int i, input logic [7:0] d);
    exp_idx.push_back(i); exp_dat.push_back(d);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (obs_dat.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (TX_LEN + 8) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      req_valid = 4'($urandom); req_data = $urandom;
      req_last = 4'($urandom);  tx_busy = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({req_ack, grant, tx_start, tx_data, err_busy} !== 18'h0) begin
        n_mis++;
        $display("FAIL reset_outputs: ack %b grant %b start %b data %h err %b, required all 0",
                 req_ack, grant, tx_start, tx_data, err_busy);
      end
    end
    req_valid = 4'h0; tx_busy = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (tx_start !== 1'b0 || grant !== 4'h0) begin
        n_mis++;
        $display("FAIL idle_after_reset: start %b grant %b, required 0/0000", tx_start, grant);
      end
    end
    drv_en = 1'b1; xmit_en = 1'b1;
  endtask

  task automatic test_single();
    bit ok; int p; logic [7:0] od; logic [3:0] oa, og; int oc; int f0;
    @(posedge clk); #2;
    p = cyc;
    push(2, 8'h41, 1'b1); expect_byte(2, 8'h41);
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL single_timeout: no tx_start, required one");
    end else begin
      void'(exp_idx.pop_front()); void'(exp_dat.pop_front());
      od = obs_dat.pop_front(); oa = obs_ack.pop_front();
      og = obs_gnt.pop_front(); oc = obs_cyc.pop_front();
      if (od !== 8'h41 || oa !== 4'b0100 || og !== 4'b0100) begin
        n_mis++;
        $display("FAIL single_byte: data %h ack %b grant %b, required 41/0100/0100", od, oa, og);
      end
      n_cmp++;
      if (oc - p !== 1) begin
        n_mis++; $display("FAIL single_latency: %0d cycles, required 1", oc - p);
      end
    end
    f0 = fall_cnt;
    for (int k = 0; k < 100 && fall_cnt == f0; k++) @(negedge clk);
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_cmp++;
    if (grant !== 4'h0) begin
      n_mis++; $display("FAIL single_grant_release: grant %b, required 0000", grant);
    end
    settle();
  endtask

  // Pointer sits at 3 after the single byte: requester 3 outranks 0.
  task automatic test_pointer();
    bit ok; int ei; logic [7:0] ed, od; logic [3:0] oa, og;
    push(0, 8'h50, 1'b1); push(3, 8'h53, 1'b1);
    expect_byte(3, 8'h53); expect_byte(0, 8'h50);
    wait_obs(2, ok);
    while (exp_idx.size() > 0) begin
      ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
      n_cmp++;
      if (obs_dat.size() == 0) begin
        n_mis++; $display("FAIL pointer_order: no byte, required %h", ed);
      end else begin
        od = obs_dat.pop_front(); oa = obs_ack.pop_front(); og = obs_gnt.pop_front();
        void'(obs_cyc.pop_front());
        if (od !== ed || oa !== 4'(1 << ei) || og !== 4'(1 << ei)) begin
          n_mis++;
          $display("FAIL pointer_order: data %h ack %b grant %b, required %h from req %0d", od, oa, og, ed, ei);
        end
      end
    end
    settle();
  endtask

  task automatic test_round_robin();
    bit ok; int ei; logic [7:0] ed, od; logic [3:0] oa, og;
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1); push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    expect_byte(1, 8'h20); expect_byte(2, 8'h30); expect_byte(3, 8'h40);
    expect_byte(0, 8'h10); expect_byte(0, 8'h11);
    wait_obs(5, ok);
    while (exp_idx.size() > 0) begin
      ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
      n_cmp++;
      if (obs_dat.size() == 0) begin
        n_mis++; $display("FAIL rr_order: no byte, required %h", ed);
      end else begin
        od = obs_dat.pop_front(); oa = obs_ack.pop_front(); og = obs_gnt.pop_front();
        void'(obs_cyc.pop_front());
        if (od !== ed || oa !== 4'(1 << ei) || og !== 4'(1 << ei)) begin
          n_mis++;
          $display("FAIL rr_order: data %h ack %b grant %b, required %h from req %0d", od, oa, og, ed, ei);
        end
      end
    end
    settle();
  endtask

  task automatic test_lock();
    bit ok; int ei; logic [7:0] ed, od; logic [3:0] oa, og;
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b1);
    push(0, 8'h05, 1'b1);
    expect_byte(1, 8'hA0); expect_byte(1, 8'hA1); expect_byte(1, 8'hA2);
    expect_byte(0, 8'h05);
    wait_obs(4, ok);
    while (exp_idx.size() > 0) begin
      ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
      n_cmp++;
      if (obs_dat.size() == 0) begin
        n_mis++; $display("FAIL lock_order: no byte, required %h", ed);
      end else begin
        od = obs_dat.pop_front(); oa = obs_ack.pop_front(); og = obs_gnt.pop_front();
        void'(obs_cyc.pop_front());
        if (od !== ed || oa !== 4'(1 << ei) || og !== 4'(1 << ei)) begin
          n_mis++;
          $display("FAIL lock_order: data %h ack %b grant %b, required %h from req %0d", od, oa, og, ed, ei);
        end
      end
    end
    settle();
  endtask

  task automatic test_lock_timeout();
    bit ok; logic [7:0] od; logic [3:0] oa; int oc; int f0; int fc;
    push(3, 8'h33, 1'b0); push(0, 8'h06, 1'b1);
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL tmo_first: no tx_start, required 33");
    end else begin
      od = obs_dat.pop_front(); oa = obs_ack.pop_front();
      void'(obs_gnt.pop_front()); void'(obs_cyc.pop_front());
      if (od !== 8'h33 || oa !== 4'b1000) begin
        n_mis++; $display("FAIL tmo_first: data %h ack %b, required 33/1000", od, oa);
      end
    end
    f0 = fall_cnt;
    for (int k = 0; k < 100 && fall_cnt == f0; k++) @(negedge clk);
    fc = fall_cyc;
    while (cyc < fc + LOCK_T) @(negedge clk);
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_mis++; $display("FAIL tmo_still_locked: grant %b, required 1000", grant);
    end
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'h0) begin
      n_mis++; $display("FAIL tmo_release: grant %b, required 0000", grant);
    end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL tmo_next: no tx_start, required 06");
    end else begin
      od = obs_dat.pop_front(); oa = obs_ack.pop_front();
      void'(obs_gnt.pop_front()); oc = obs_cyc.pop_front();
      if (od !== 8'h06 || oa !== 4'b0001 || oc !== fc + LOCK_T + 2) begin
        n_mis++;
        $display("FAIL tmo_next: data %h ack %b at +%0d, required 06/0001 at +%0d",
                 od, oa, oc - fc, LOCK_T + 2);
      end
    end
    settle();
  endtask

  task automatic test_busy_fault();
    bit ok; logic [7:0] od; logic [3:0] oa; int s; int oc;
    fault = 1'b1;
    push(1, 8'h77, 1'b1); push(2, 8'h78, 1'b1);
    wait_obs(1, ok);
    s = 0;
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL fault_first: no tx_start, required 77");
    end else begin
      od = obs_dat.pop_front(); oa = obs_ack.pop_front();
      void'(obs_gnt.pop_front()); s = obs_cyc.pop_front();
      if (od !== 8'h77 || oa !== 4'b0010) begin
        n_mis++; $display("FAIL fault_first: data %h ack %b, required 77/0010", od, oa);
      end
    end
    repeat (3) @(negedge clk);
    fault = 1'b0;
    for (int k = 0; k < 60 && err_cyc.size() == 0; k++) @(negedge clk);
    n_cmp++;
    if (err_cyc.size() == 0) begin
      n_mis++; $display("FAIL fault_err: no err_busy, required pulse");
    end else if (err_cyc[0] - s !== BUSY_W) begin
      n_mis++; $display("FAIL fault_err: err after %0d cycles, required %0d", err_cyc[0] - s, BUSY_W);
    end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok || err_cyc.size() == 0) begin
      n_mis++; $display("FAIL fault_next: no tx_start, required 78");
    end else begin
      od = obs_dat.pop_front(); oa = obs_ack.pop_front();
      void'(obs_gnt.pop_front()); oc = obs_cyc.pop_front();
      if (od !== 8'h78 || oa !== 4'b0100 || oc !== err_cyc[0] + 1) begin
        n_mis++;
        $display("FAIL fault_next: data %h ack %b at err+%0d, required 78/0100 at err+1",
                 od, oa, oc - err_cyc[0]);
      end
    end
    settle();
    n_cmp++;
    if (err_cyc.size() !== 1) begin
      n_mis++; $display("FAIL fault_pulse_count: %0d err cycles, required 1", err_cyc.size());
    end
  endtask

  task automatic test_final();
    n_cmp++;
    if (stray !== 0) begin
      n_mis++; $display("FAIL stray_ack: %0d acks without start, required 0", stray);
    end
    n_cmp++;
    if (obs_dat.size() !== 0) begin
      n_mis++; $display("FAIL extra_bytes: %0d unexpected bytes, required 0", obs_dat.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pointer();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_busy_fault();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
